// File: rtl/uart_tx_sched_pkg.sv
// Shared types, sizes and checksum helper for the UART message scheduler.
// UART_TX_SCHED_CHECKSUM_EN adds a fifth XOR checksum byte to each message.
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_START,
        WAIT_DONE,
        GAP,
        DONE
    } sched_state_t;

    localparam int MSG_BYTES = 4;

`ifdef UART_TX_SCHED_CHECKSUM_EN
    localparam int TX_BYTES = MSG_BYTES + 1;
`else
    localparam int TX_BYTES = MSG_BYTES;
`endif

    localparam int BIDX_W  = $clog2(TX_BYTES);
    localparam int SHIFT_W = 8 * TX_BYTES;

    localparam logic [BIDX_W-1:0] LAST_IDX =
        BIDX_W'(TX_BYTES - 1);

    function automatic logic [7:0] msg_checksum(
        input logic [31:0] msg
    );
        return msg[7:0] ^ msg[15:8]
             ^ msg[23:16] ^ msg[31:24];
    endfunction

endpackage

// File: rtl/uart_tx_msg_scheduler_if.sv
// Byte handshake between the message scheduler and the UART transmitter.
// master drives the byte strobe, slave reports busy.
interface uart_tx_msg_scheduler_if;

    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       Tx_BUSY;

    modport master (
        output Tx_EN,
        output Tx_WR,
        output Tx_DATA,
        input  Tx_BUSY
    );

    modport slave (
        input  Tx_EN,
        input  Tx_WR,
        input  Tx_DATA,
        output Tx_BUSY
    );

endinterface

// File: rtl/tx_rr_arbiter.sv
// Two-input round-robin arbiter; the requester not granted last wins a tie.
// Purely combinational, the caller owns the last_grant register.
module tx_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = 1'b0;
        unique case (1'b1)
            req0 & req1:  gnt_id = ~last_grant;
            req1 & ~req0: gnt_id = 1'b1;
            default:      gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_msg_scheduler.sv
// Round-robin scheduler feeding 4-byte messages into a UART transmitter.
// Define UART_TX_SCHED_CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_msg_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] msg0,
    input  logic [31:0] msg1,
    output logic        ack0,
    output logic        ack1,
    uart_tx_msg_scheduler_if.master tx,
    output logic        sched_busy,
    output logic        grant_id,
    output logic        timeout_err
);

    localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W  =
        (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t        state_q, state_d;
    logic                last_grant_q;
    logic                grant_q;
    logic                abort_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic [7:0]          data_q;

    logic                gnt_valid;
    logic                gnt_id;
    logic [31:0]         msg_sel;
    logic [SHIFT_W-1:0]  msg_ext;

    logic                grant_load;
    logic                next_byte;
    logic                idx_inc;
    logic                abort_set;

    tx_rr_arbiter u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign msg_sel = gnt_id ? msg1 : msg0;

`ifdef UART_TX_SCHED_CHECKSUM_EN
    assign msg_ext = {msg_checksum(msg_sel), msg_sel};
`else
    assign msg_ext = msg_sel;
`endif

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        next_byte  = 1'b0;
        idx_inc    = 1'b0;
        abort_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d    = WRITE;
                    grant_load = 1'b1;
                end
            end
            WRITE: state_d = WAIT_START;
            WAIT_START: begin
                // a busy already high here counts as the start
                if (tx.Tx_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = DONE;
                    abort_set = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx.Tx_BUSY) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d   = WRITE;
                            next_byte = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = WRITE;
                    next_byte = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            abort_q      <= 1'b0;
            byte_idx_q   <= '0;
            wait_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
        end else begin
            state_q <= state_d;

            if (grant_load) begin
                grant_q    <= gnt_id;
                shift_q    <= msg_ext;
                data_q     <= msg_sel[7:0];
                byte_idx_q <= '0;
                abort_q    <= 1'b0;
            end

            // Tx_DATA only changes on entry to WRITE
            if (next_byte) begin
                shift_q <= shift_q >> 8;
                data_q  <= shift_q[15:8];
            end

            if (idx_inc)
                byte_idx_q <= byte_idx_q + 1'b1;

            if (state_q == WRITE)
                wait_cnt_q <= '0;
            else if (state_q == WAIT_START &&
                     wait_cnt_q != WAIT_LAST)
                wait_cnt_q <= wait_cnt_q + 1'b1;

            if (idx_inc)
                gap_cnt_q <= '0;
            else if (state_q == GAP &&
                     gap_cnt_q != GAP_LAST)
                gap_cnt_q <= gap_cnt_q + 1'b1;

            if (abort_set)
                abort_q <= 1'b1;

            if (state_q == DONE)
                last_grant_q <= grant_q;
        end
    end

    assign tx.Tx_EN     = (state_q != IDLE);
    assign tx.Tx_WR     = (state_q == WRITE);
    assign tx.Tx_DATA   = (state_q == IDLE) ? 8'h00 : data_q;
    assign sched_busy   = (state_q != IDLE);
    assign grant_id     = (state_q != IDLE) & grant_q;
    assign ack0         = (state_q == DONE) & ~grant_q;
    assign ack1         = (state_q == DONE) & grant_q;
    assign timeout_err  = (state_q == DONE) & abort_q;

endmodule

// File: tb/tb_uart_tx_msg_scheduler.sv
// Directed bench for uart_tx_msg_scheduler with a cycle-counting busy model.
// A second instance with GAP_CYCLES=0 covers the zero-gap path.
module tb_uart_tx_msg_scheduler;

    localparam int GAP    = 3;
    localparam int TMO    = 20;
    localparam int BLEN   = 100;
    localparam int BLEN_Z = 1;
`ifdef UART_TX_SCHED_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic id;
        logic terr;
    } ack_t;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] m0;
        logic [31:0] m1;
        int          n;
        logic        id_a;
        logic        id_b;
    } vec_t;

    logic        Clk = 1'b0;
    logic        reset;
    logic        req0, req1, req0_z;
    logic [31:0] msg0, msg1;
    logic        ack0, ack1, sched_busy, grant_id, timeout_err;
    logic        ack0_z, ack1_z, sched_busy_z, grant_id_z, timeout_err_z;

    int cyc = 0;
    int busy_len;
    int busy_cnt, busy_cnt_z;
    int checks = 0;
    int errors = 0;

    wr_t  wr_q[$];
    wr_t  wrz_q[$];
    ack_t ack_q[$];
    ack_t ackz_q[$];

    uart_tx_msg_scheduler_if tx_if ();
    uart_tx_msg_scheduler_if tz_if ();

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    uart_tx_msg_scheduler #(
        .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)
    ) dut (
        .Clk(Clk), .reset(reset),
        .req0(req0), .req1(req1),
        .msg0(msg0), .msg1(msg1),
        .ack0(ack0), .ack1(ack1),
        .tx(tx_if),
        .sched_busy(sched_busy), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    uart_tx_msg_scheduler #(
        .GAP_CYCLES(0), .START_TIMEOUT(TMO)
    ) dut_z (
        .Clk(Clk), .reset(reset),
        .req0(req0_z), .req1(1'b0),
        .msg0(msg0), .msg1(msg1),
        .ack0(ack0_z), .ack1(ack1_z),
        .tx(tz_if),
        .sched_busy(sched_busy_z), .grant_id(grant_id_z),
        .timeout_err(timeout_err_z)
    );

    // busy rises at the edge ending the WR cycle and lasts busy_len cycles
    always @(posedge Clk or posedge reset)
        if (reset) busy_cnt <= 0;
        else if (tx_if.Tx_WR && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign tx_if.Tx_BUSY = (busy_cnt > 0);

    always @(posedge Clk or posedge reset)
        if (reset) busy_cnt_z <= 0;
        else if (tz_if.Tx_WR) busy_cnt_z <= BLEN_Z;
        else if (busy_cnt_z > 0) busy_cnt_z <= busy_cnt_z - 1;
    assign tz_if.Tx_BUSY = (busy_cnt_z > 0);

    always @(negedge Clk) begin
        if (tx_if.Tx_WR) wr_q.push_back('{cyc, tx_if.Tx_DATA});
        if (ack0 || ack1) ack_q.push_back('{cyc, ack1, timeout_err});
        if (tz_if.Tx_WR) wrz_q.push_back('{cyc, tz_if.Tx_DATA});
        if (ack0_z || ack1_z)
            ackz_q.push_back('{cyc, ack1_z, timeout_err_z});
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] m,
                                            input int k);
        logic [7:0] b[5];
        for (int i = 0; i < 4; i++) b[i] = m[8*i +: 8];
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        return b[k];
    endfunction

    task automatic serve(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge Clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (!req0 && !req1 && !sched_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // per byte: WR cycle + busy cycles + fall-sample cycle + gap
    task automatic check_msg(input string nm, input logic id,
                             input logic [31:0] m, input int first_wr,
                             output int ack_cyc);
        wr_t  w;
        ack_t a;
        int   prev;
        ack_cyc = 0;
        prev = 0;
        chk({nm, " events"}, 64'(wr_q.size() >= NB && ack_q.size() >= 1), 1);
        if (wr_q.size() < NB || ack_q.size() < 1) return;
        for (int k = 0; k < NB; k++) begin
            w = wr_q.pop_front();
            chk($sformatf("%s byte%0d", nm, k), w.data, exp_byte(m, k));
            if (k == 0) chk({nm, " first_wr"}, w.cyc, first_wr);
            else chk($sformatf("%s spacing%0d", nm, k),
                     w.cyc - prev, BLEN + GAP + 2);
            prev = w.cyc;
        end
        a = ack_q.pop_front();
        chk({nm, " ack_id"}, a.id, id);
        chk({nm, " terr"}, a.terr, 0);
        chk({nm, " ack_cyc"}, a.cyc, prev + BLEN + 2);
        ack_cyc = a.cyc;
    endtask

    initial begin
        vec_t vt[6];
        int   t0, a_cyc, prev;
        bit   ok;
        wr_t  w;
        ack_t a;

        vt[0] = '{1, 1, 32'h44332211, 32'h88776655, 2, 0, 1};
        vt[1] = '{1, 1, 32'hA1B2C3D4, 32'h55667788, 2, 0, 1};
        vt[2] = '{1, 0, 32'h44332211, 32'h00000000, 1, 0, 0};
        vt[3] = '{1, 1, 32'h12345678, 32'h9ABCDEF0, 2, 1, 0};
        vt[4] = '{0, 1, 32'h00000000, 32'h0F0F00FF, 1, 1, 1};
        vt[5] = '{1, 0, 32'hFF0000FF, 32'h00000000, 1, 0, 0};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_z = 1'b0;
        msg0 = '0; msg1 = '0;
        busy_len = BLEN;
        repeat (3) @(negedge Clk);
        chk("reset outputs",
            {ack0, ack1, tx_if.Tx_EN, tx_if.Tx_WR, tx_if.Tx_DATA,
             sched_busy, grant_id, timeout_err}, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge Clk);
            msg0 = vt[v].m0; msg1 = vt[v].m1;
            req0 = vt[v].r0; req1 = vt[v].r1;
            t0 = cyc + 1;
            serve(3000, ok);
            chk($sformatf("v%0d serve", v), ok, 1);
            check_msg($sformatf("v%0d a", v), vt[v].id_a,
                      vt[v].id_a ? vt[v].m1 : vt[v].m0, t0, a_cyc);
            if (vt[v].n == 2)
                check_msg($sformatf("v%0d b", v), vt[v].id_b,
                          vt[v].id_b ? vt[v].m1 : vt[v].m0,
                          a_cyc + 2, a_cyc);
            chk($sformatf("v%0d drained", v), wr_q.size() + ack_q.size(), 0);
            chk($sformatf("v%0d idle outs", v),
                {tx_if.Tx_EN, tx_if.Tx_WR, tx_if.Tx_DATA, grant_id}, 0);
            wr_q.delete(); ack_q.delete();
        end

        // transmitter never starts
        busy_len = 0;
        @(negedge Clk);
        msg0 = 32'hCAFEF00D; req0 = 1'b1; t0 = cyc + 1;
        serve(200, ok);
        chk("tmo serve", ok, 1);
        chk("tmo wr count", wr_q.size(), 1);
        chk("tmo ack count", ack_q.size(), 1);
        if (wr_q.size() == 1 && ack_q.size() == 1) begin
            w = wr_q.pop_front();
            a = ack_q.pop_front();
            chk("tmo wr cyc", w.cyc, t0);
            chk("tmo wr data", w.data, 8'h0D);
            chk("tmo ack cyc", a.cyc, t0 + TMO + 1);
            chk("tmo ack id", a.id, 0);
            chk("tmo terr", a.terr, 1);
        end
        chk("tmo idle", {sched_busy, tx_if.Tx_EN}, 0);
        wr_q.delete(); ack_q.delete();

        // reset while byte 2 is in flight
        busy_len = BLEN;
        @(negedge Clk);
        msg0 = 32'h13579BDF; msg1 = 32'h2468ACE0; req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge Clk);
            ok = (wr_q.size() == 3);
        end
        chk("rst reached byte2", ok, 1);
        repeat (10) @(negedge Clk);
        #2 reset = 1'b1;
        #1 chk("rst async outputs",
               {ack0, ack1, tx_if.Tx_EN, tx_if.Tx_WR, tx_if.Tx_DATA,
                sched_busy, grant_id, timeout_err}, 0);
        req0 = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst no ack", ack_q.size(), 0);
        reset = 1'b0;
        wr_q.delete(); ack_q.delete();
        @(negedge Clk);
        req1 = 1'b1; t0 = cyc + 1;
        serve(2000, ok);
        chk("rst serve", ok, 1);
        check_msg("rst req1", 1, 32'h2468ACE0, t0, a_cyc);
        wr_q.delete(); ack_q.delete();

        // zero gap, busy lasts one cycle so it must be caught at once
        @(negedge Clk);
        msg0 = 32'hA5C39617; req0_z = 1'b1; t0 = cyc + 1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge Clk);
            if (ack0_z) req0_z = 1'b0;
            ok = !req0_z && !sched_busy_z;
        end
        chk("gap0 serve", ok, 1);
        chk("gap0 wr count", wrz_q.size(), NB);
        chk("gap0 ack count", ackz_q.size(), 1);
        if (wrz_q.size() == NB && ackz_q.size() == 1) begin
            prev = 0;
            for (int k = 0; k < NB; k++) begin
                w = wrz_q.pop_front();
                chk($sformatf("gap0 byte%0d", k), w.data,
                    exp_byte(32'hA5C39617, k));
                if (k == 0) chk("gap0 first_wr", w.cyc, t0);
                else chk($sformatf("gap0 spacing%0d", k),
                         w.cyc - prev, BLEN_Z + 2);
                prev = w.cyc;
            end
            a = ackz_q.pop_front();
            chk("gap0 ack cyc", a.cyc, prev + BLEN_Z + 2);
            chk("gap0 ack id", a.id, 0);
            chk("gap0 terr", a.terr, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
